// File: rtl/key_loader_if.sv
// Host byte stream in, container key-change/password out, plus loader status.
interface key_loader_if;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         key_val;
    logic         sgn_key_ch;
    logic [127:0] key_in;
    logic [7:0]   password;
    logic         busy;
    logic         done;
    logic         err;

    modport slave (
        input  byte_in, byte_valid, key_val,
        output byte_ready, sgn_key_ch, key_in, password, busy, done, err
    );

    modport master (
        output byte_in, byte_valid, key_val,
        input  byte_ready, sgn_key_ch, key_in, password, busy, done, err
    );
endinterface

// File: rtl/key_loader.sv
// Collects a 16-byte key, commits it, unlocks with PASSWORD, waits for key_val.
// Latency: 4 cycles last byte -> done. Backpressure: byte_ready low outside IDLE/COLLECT.
module key_loader #(
    parameter logic [7:0]  PASSWORD = 8'b10101010,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic         clk,
    input  logic         reset,
    key_loader_if.slave  kif
);
    localparam logic [15:0] TMO = 16'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, COLLECT, COMMIT, UNLOCK, WAIT_VAL} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [15:0]    tmo_q, tmo_d;
    logic [127:0]   key_q, key_d;
    logic           sgn_q, sgn_d;
    logic [7:0]     pwd_q, pwd_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           rdy;
    logic           xfer;

    assign rdy  = (state_q == IDLE) || (state_q == COLLECT);
    assign xfer = rdy && kif.byte_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        key_d   = key_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE, COLLECT: begin
                if (xfer) begin
                    key_d   = {key_q[119:0], kif.byte_in};
                    cnt_d   = cnt_q + 4'd1;
                    state_d = (cnt_q == 4'd15) ? COMMIT : COLLECT;
                end
            end
            COMMIT: state_d = UNLOCK;
            UNLOCK: begin
                state_d = WAIT_VAL;
                tmo_d   = 16'd0;
            end
            WAIT_VAL: begin
                // key_val wins over a timeout landing in the same cycle
                if (kif.key_val) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (tmo_q == TMO) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        sgn_d  = (state_d == COMMIT);
        pwd_d  = (state_d == UNLOCK) ? PASSWORD : ~PASSWORD;
        busy_d = !((state_d == IDLE) || ((state_d == COLLECT) && (cnt_d == 4'd0)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            tmo_q   <= 16'd0;
            key_q   <= 128'h0;
            sgn_q   <= 1'b0;
            pwd_q   <= ~PASSWORD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            key_q   <= key_d;
            sgn_q   <= sgn_d;
            pwd_q   <= pwd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign kif.byte_ready = rdy;
    assign kif.sgn_key_ch = sgn_q;
    assign kif.key_in     = key_q;
    assign kif.password   = pwd_q;
    assign kif.busy       = busy_q;
    assign kif.done       = done_q;
    assign kif.err        = err_q;
endmodule

// File: tb/tb_key_loader.sv
// Bench for key_loader with a behavioural key container and a key scoreboard.
module tb_key_loader;
    logic clk;
    logic reset;
    key_loader_if ifc();

    key_loader #(.PASSWORD(8'hAA), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .kif   (ifc.slave)
    );

    // container model: latch on strobe, licence on password match
    logic [127:0] key_out = 128'h0;
    logic         lic     = 1'b0;
    logic         kv_tie  = 1'b0;
    always @(posedge clk) begin
        if (ifc.sgn_key_ch) begin
            key_out <= ifc.key_in;
            lic     <= 1'b0;
        end else if (ifc.password == 8'hAA) begin
            lic <= 1'b1;
        end
    end
    assign ifc.key_val = kv_tie ? 1'b0 : lic;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [127:0] key;
        bit           stall;
        bit           tie;
        int           exp_done;
        int           exp_err;
    } vec_t;

    vec_t         vec [5];
    logic [127:0] sbq [$];
    int checks = 0;
    int errors = 0;
    int sgn_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [127:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (ifc.sgn_key_ch) begin
                    sgn_cnt++;
                    chk("mutex_sgn_pwd", 128'(ifc.password == 8'hAA), 128'd0);
                end
                if (ifc.done) begin
                    done_cnt++;
                    if (sbq.size() == 0) begin
                        chk("done_unexpected", 128'd1, 128'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk("container_key", key_out, e);
                        chk("key_val_at_done", 128'(ifc.key_val), 128'd1);
                    end
                end
                if (ifc.err) err_cnt++;
            end
        end
    endtask

    // sends the first n bytes of k; returns #1 after the edge accepting the last one
    task automatic send_key(input logic [127:0] k, input bit stall, input int n);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (stall && ($urandom_range(0, 1) == 1)) begin
                ifc.byte_valid = 1'b0;
                ifc.byte_in    = 8'hCC;
            end else begin
                ifc.byte_valid = 1'b1;
                ifc.byte_in    = k[127-8*i -: 8];
                if (ifc.byte_ready) i++;
            end
        end
        if (i < n) chk("send_timeout", 128'(i), 128'(n));
        @(posedge clk);
        #1;
        ifc.byte_valid = 1'b0;
    endtask

    // called at E0+1: checks commit/unlock/wait timing while offering stray bytes
    task automatic finish_load(input logic [127:0] k, input bit tie);
        chk("E0_sgn_key_ch", 128'(ifc.sgn_key_ch), 128'd1);
        chk("E0_key_in", ifc.key_in, k);
        chk("E0_byte_ready", 128'(ifc.byte_ready), 128'd0);
        ifc.byte_valid = 1'b1;
        ifc.byte_in    = 8'hEE;
        @(posedge clk); #1;
        chk("E1_password", 128'(ifc.password), 128'hAA);
        chk("E1_sgn_key_ch", 128'(ifc.sgn_key_ch), 128'd0);
        chk("E1_byte_ready", 128'(ifc.byte_ready), 128'd0);
        @(posedge clk); #1;
        chk("E2_password", 128'(ifc.password), 128'h55);
        chk("E2_byte_ready", 128'(ifc.byte_ready), 128'd0);
        chk("E2_busy", 128'(ifc.busy), 128'd1);
        if (!tie) begin
            @(posedge clk); #1;
            ifc.byte_valid = 1'b0;
            chk("E3_done", 128'(ifc.done), 128'd1);
            chk("E3_byte_ready", 128'(ifc.byte_ready), 128'd1);
            chk("E3_busy", 128'(ifc.busy), 128'd0);
            chk("E3_key_in_held", ifc.key_in, k);
        end else begin
            ifc.byte_valid = 1'b0;
            for (int c = 1; c <= 17; c++) begin
                @(posedge clk); #1;
                chk($sformatf("tmo_err_c%0d", c), 128'(ifc.err), 128'(c == 17));
                chk($sformatf("tmo_done_c%0d", c), 128'(ifc.done), 128'd0);
            end
            @(posedge clk); #1;
            chk("tmo_idle_ready", 128'(ifc.byte_ready), 128'd1);
            chk("tmo_idle_busy", 128'(ifc.busy), 128'd0);
            chk("tmo_err_single", 128'(ifc.err), 128'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0, s0;
        vec[0] = '{128'h000102030405060708090A0B0C0D0E0F, 1'b0, 1'b0, 1, 0};
        vec[1] = '{128'hDEADBEEF0123456789ABCDEFF00DCAFE, 1'b1, 1'b0, 1, 0};
        vec[2] = '{128'hFFEEDDCCBBAA99887766554433221100, 1'b0, 1'b1, 0, 1};
        vec[3] = '{128'h11223344556677889900AABBCCDDEEFF, 1'b1, 1'b0, 1, 0};
        vec[4] = '{128'h0F0E0D0C0B0A09080706050403020100, 1'b0, 1'b0, 1, 0};

        ifc.byte_in    = 8'h00;
        ifc.byte_valid = 1'b0;
        reset          = 1'b1;
        fork
            monitor();
        join_none
        #1;
        chk("rst_password", 128'(ifc.password), 128'h55);
        chk("rst_key_in", ifc.key_in, 128'h0);
        chk("rst_sgn", 128'(ifc.sgn_key_ch), 128'd0);
        chk("rst_busy", 128'(ifc.busy), 128'd0);
        chk("rst_done_err", {126'd0, ifc.done, ifc.err}, 128'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready", 128'(ifc.byte_ready), 128'd1);

        // reset mid-collect, then a fresh key
        send_key(128'h99999999999999999999999999999999, 1'b0, 7);
        chk("partial_busy", 128'(ifc.busy), 128'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_key_in", ifc.key_in, 128'h0);
        chk("midrst_busy", 128'(ifc.busy), 128'd0);
        chk("midrst_password", 128'(ifc.password), 128'h55);
        chk("midrst_ready", 128'(ifc.byte_ready), 128'd1);
        @(negedge clk);
        reset = 1'b0;
        s0 = sgn_cnt;
        sbq.push_back(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        send_key(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, 1'b0, 16);
        finish_load(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, 1'b0);
        @(negedge clk);
        chk("midrst_one_strobe", 128'(sgn_cnt - s0), 128'd1);

        for (int v = 0; v < 5; v++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            kv_tie = vec[v].tie;
            if (!vec[v].tie) sbq.push_back(vec[v].key);
            send_key(vec[v].key, vec[v].stall, 16);
            finish_load(vec[v].key, vec[v].tie);
            @(negedge clk);
            chk($sformatf("vec%0d_done_cnt", v), 128'(done_cnt - d0), 128'(vec[v].exp_done));
            chk($sformatf("vec%0d_err_cnt", v), 128'(err_cnt - e0), 128'(vec[v].exp_err));
            chk($sformatf("vec%0d_container_key", v), key_out, vec[v].key);
            kv_tie = 1'b0;
        end

        repeat (2) @(negedge clk);
        chk("final_container_key", key_out, vec[4].key);
        chk("final_key_val", 128'(ifc.key_val), 128'd1);
        chk("scoreboard_empty", 128'(sbq.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_loader.md
# key_loader

Provisioning front end for the key container. Accepts a 128-bit key as 16 bytes over a valid/ready byte stream, then drives the container's key-change and password inputs in the correct order: commit the key, re-license it, then confirm that the container reports `key_val`. It sits between the host/config path and the container, and provides the writer side of the container's interface.

## Interface
- `PASSWORD`, default `8'b10101010`: licence password presented to the container; must match the container's check value.
- `TIMEOUT`, default `16`: cycles to wait for `key_val` after unlock before flagging an error; legal range 1..65535.

- `clk` input 1: single clock; all state updates on posedge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `byte_in` input 8: key byte from host.
- `byte_valid` input 1: `byte_in` valid.
- `byte_ready` output 1: loader can accept a byte.
- `key_val` input 1: from container `key_val`.
- `sgn_key_ch` output 1: to container `sgn_key_ch`; one-cycle commit strobe.
- `key_in` output 128: to container `key_in`; assembled key.
- `password` output 8: to container `password`.
- `busy` output 1: high in any state other than IDLE/COLLECT with count 0.
- `done` output 1: one-cycle pulse when the container confirms the key.
- `err` output 1: one-cycle pulse on `key_val` timeout.

## Operation
- All outputs are registered except `byte_ready`, which decodes from state.
- **FSM states:** IDLE, COLLECT, COMMIT, UNLOCK, WAIT_VAL.
- **IDLE / COLLECT:**
  - `byte_ready` = 1.
  - A transfer occurs when `byte_valid && byte_ready`.
  - Each transfer shifts the assembly register: `key_in <= {key_in[119:0], byte_in}`. The first byte ends up in `[127:120]`.
  - A 4-bit byte count increments on each transfer.
  - IDLE goes to COLLECT on the first transfer.
  - The 16th transfer (count = 15) wraps the count to 0 and moves to COMMIT.
- **COMMIT:** `sgn_key_ch` = 1 for exactly this cycle. The container latches `key_in` and clears its licence. Next state is UNLOCK.
- **UNLOCK:** `password` = `PASSWORD` for exactly this cycle. The container sets its licence at the edge ending this cycle. Next state is WAIT_VAL; the timeout counter clears.
- **WAIT_VAL:**
  - If `key_val` = 1, pulse `done` next cycle and go to IDLE.
  - Otherwise the counter increments.
  - When the counter reaches `TIMEOUT` without `key_val`, pulse `err` next cycle and go to IDLE.
  - `key_val` has priority if it arrives on the same cycle the counter reaches `TIMEOUT`.
- **Password outside UNLOCK:** `password` = `~PASSWORD`, so it never matches by accident, including when `PASSWORD` = 0.
- **Byte handling outside collection:** `byte_ready` = 0 in COMMIT, UNLOCK and WAIT_VAL; bytes offered there are not consumed.
- **`key_in` hold:** `key_in` holds the last assembled key until the next COMMIT-bound byte shifts it. The container only samples it under `sgn_key_ch`.
- **Widths:** timeout counter is 16 bits; the compare uses `TIMEOUT` zero-extended.

## Timing
- **Reset values** (asserted, or released mid-operation):
  - state = IDLE, count = 0, timeout counter = 0.
  - `key_in` = 128'h0, `sgn_key_ch` = 0, `password` = `~PASSWORD`.
  - `done` = 0, `err` = 0, `busy` = 0, `byte_ready` = 1 after release.
- **Reset mid-operation:** discards any partial key; no strobe or pulse is emitted.
- **Latency:** the 16th byte is accepted at edge E0.
  - `sgn_key_ch` is high in cycle E0..E1.
  - `password` = `PASSWORD` in cycle E1..E2.
  - The container's `key_val` rises in cycle E2..E3.
  - `done` is high in cycle E3..E4; IDLE and `byte_ready` = 1 from E3.
  - Total: 4 cycles from last byte to `done`.
- **Back-to-back bytes:** `byte_valid` held high streams 16 bytes in 16 cycles.
- **Stalls:** gaps in `byte_valid` stall without data loss.
- **Mutual exclusion:** `sgn_key_ch` and `password == PASSWORD` are never high in the same cycle.
- **Error latency:** with `key_val` stuck low, `err` pulses `TIMEOUT` + 1 cycles after WAIT_VAL entry.

## Test plan
- **Reset values:** assert reset mid-cycle (asynchronous) -> all outputs at reset values immediately, `password` = 8'h55.
- **Normal load:** stream bytes 8'h00..8'h0F back-to-back with a container model attached.
  - `key_in` = 128'h000102030405060708090A0B0C0D0E0F at COMMIT.
  - `sgn_key_ch` is a single cycle; `password` = 8'hAA the next cycle.
  - `done` arrives 4 cycles after the last byte.
  - Container `key_out` equals the key.
- **Stalled input:** toggle `byte_valid` randomly, and offer extra bytes during COMMIT..WAIT_VAL -> same key assembled; extra bytes are not accepted (`byte_ready` = 0).
- **Timeout:** tie `key_val` = 0, `TIMEOUT` = 16 -> `err` pulses 17 cycles after WAIT_VAL entry; `done` never asserts; return to IDLE.
- **Reset mid-collect:** reset after 7 bytes, then send 16 new bytes -> the key contains only the new bytes, and exactly one `sgn_key_ch` is seen.
- **Reload:** two consecutive 16-byte loads with different keys -> two `done` pulses; the container holds the second key with `key_val` = 1.
